output_port_unit: RTL and testbench

- One instance per router output port, directly downstream of the Switch stage.
- Receives per-input requests for this output (one column of the Switch's outport request matrix) and returns the one-hot outport ack.
- Round-robin arbitration with wormhole locking: the winning input owns the port from head flit to tail flit.
- Registers the granted flit toward the neighbour router or local sink, under credit-based flow control.

---
 rtl/output_port_unit.sv | 115 +++++++++++
 tb/tb_output_port_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/output_port_unit.sv
// output_port_unit: round-robin, wormhole-locked output port with a registered flit stage and credit-based flow control
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_outport_req       per-input requests for this output
//   o_outport_ack       one-hot (or zero) combinational grant
//   i_s2o               flit from the Switch for the granted input
//   i_credit_in         downstream freed one buffer slot
//   o_flit, o_valid     registered outgoing flit and its valid
//   o_credit_overflow   sticky: credit returned while already full
//   o_busy              port locked to a packet
package router_pkg;
  localparam int NUM_OF_PORTS = 5;
  typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} PORT_T;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_type_t;
  typedef struct packed {
    flit_type_t  flit_type;
    logic [15:0] data;
  } router_pipeline_bus_t;
endpackage

module output_port_unit
  import router_pkg::*;
#(
  parameter PORT_T PORT_ID      = LOCAL,
  parameter int    CREDIT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_OF_PORTS-1:0] i_outport_req,
  output logic [NUM_OF_PORTS-1:0] o_outport_ack,
  input  router_pipeline_bus_t    i_s2o,
  input  logic                    i_credit_in,
  output router_pipeline_bus_t    o_flit,
  output logic                    o_valid,
  output logic                    o_credit_overflow,
  output logic                    o_busy
);
  localparam int NP = NUM_OF_PORTS;
  localparam int PW = $clog2(NP);
  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_credits;
  logic [PW-1:0]        r_rr_ptr, r_owner;
  router_pipeline_bus_t r_flit;
  logic                 r_valid, r_overflow;
  logic [NP-1:0]        w_rr_grant, w_own_mask, w_ack;
  logic [PW:0]          w_scan;
  logic [PW-1:0]        w_winner, w_rr_next;
  logic                 w_xfer;
  // scan downward so the lowest offset from r_rr_ptr is written last and wins
  always_comb begin
    w_rr_grant = '0;
    w_scan = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + (PW+1)'(k);
      w_scan = (w_scan >= (PW+1)'(NP)) ? w_scan - (PW+1)'(NP) : w_scan;
      if (i_outport_req[w_scan[PW-1:0]]) begin
        w_rr_grant = '0;
        w_rr_grant[w_scan[PW-1:0]] = 1'b1;
      end
    end
  end
  always_comb begin
    w_own_mask = '0;
    w_own_mask[r_owner] = 1'b1;
  end
  // ack is held off during reset and whenever downstream has no room
  assign w_ack = (!rst_n || r_credits == '0) ? '0 :
                 (r_state == LOCKED) ? (w_own_mask & i_outport_req) : w_rr_grant;
  assign w_xfer = |(w_ack & i_outport_req);
  always_comb begin
    w_winner = '0;
    for (int k = 0; k < NP; k++)
      if (w_ack[k]) w_winner = PW'(k);
  end
  assign w_rr_next = (w_winner == PW'(NP - 1)) ? '0 : w_winner + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_credits  <= CW'(CREDIT_DEPTH);
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_flit     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) r_flit <= i_s2o;
      if (w_xfer && r_state == IDLE) begin
        r_rr_ptr <= w_rr_next;
        if (i_s2o.flit_type == HEAD) begin
          r_state <= LOCKED;
          r_owner <= w_winner;
        end
      end
      if (w_xfer && r_state == LOCKED && i_s2o.flit_type == TAIL) r_state <= IDLE;
      if (w_xfer && !i_credit_in) r_credits <= r_credits - 1'b1;
      else if (!w_xfer && i_credit_in) begin
        if (r_credits == CW'(CREDIT_DEPTH)) r_overflow <= 1'b1;
        else r_credits <= r_credits + 1'b1;
      end
    end
  end
  assign o_outport_ack     = w_ack;
  assign o_flit            = r_flit;
  assign o_valid           = r_valid;
  assign o_credit_overflow = r_overflow;
  assign o_busy            = (r_state == LOCKED);
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_outport_ack))
    else $error("output port %0d: ack not one-hot", PORT_ID);
  a_ack_owner: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == LOCKED) |-> ((o_outport_ack & ~w_own_mask) == '0))
    else $error("output port %0d: ack to non-owner while locked", PORT_ID);
endmodule

// File: tb/tb_output_port_unit.sv
// tb_output_port_unit: scoreboard bench for output_port_unit (depth-4 and depth-2 instances)
module tb_output_port_unit;
  import router_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] req1 = '0, req2 = '0, ack1, ack2;
  logic cr1 = 1'b0, cr2 = 1'b0;
  router_pipeline_bus_t s1 = '0, s2 = '0, f1, f2;
  logic v1, v2, ov1, ov2, b1, b2;
  int tests = 0;
  int fails = 0;
  router_pipeline_bus_t q1[$], q2[$];
  always #5 clk = ~clk;
  output_port_unit #(.PORT_ID(EAST), .CREDIT_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_outport_req(req1), .o_outport_ack(ack1), .i_s2o(s1),
    .i_credit_in(cr1), .o_flit(f1), .o_valid(v1), .o_credit_overflow(ov1), .o_busy(b1));
  output_port_unit #(.PORT_ID(WEST), .CREDIT_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_outport_req(req2), .o_outport_ack(ack2), .i_s2o(s2),
    .i_credit_in(cr2), .o_flit(f2), .o_valid(v2), .o_credit_overflow(ov2), .o_busy(b2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    router_pipeline_bus_t e;
    if (v1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon1 unexpected flit: got %0h expected none", f1);
      end else begin
        e = q1.pop_front();
        chk("mon1 flit", 32'(f1), 32'(e));
      end
    end
    if (v2) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon2 unexpected flit: got %0h expected none", f2);
      end else begin
        e = q2.pop_front();
        chk("mon2 flit", 32'(f2), 32'(e));
      end
    end
  end
  task automatic step(input int u, input logic [4:0] r, input flit_type_t t, input logic [15:0] d,
                      input logic c, input logic [4:0] ea, input logic eb, input string nm);
    router_pipeline_bus_t f;
    f.flit_type = t;
    f.data = d;
    @(negedge clk); #1;
    if (u == 0) begin req1 = r; s1 = f; cr1 = c; end
    else begin req2 = r; s2 = f; cr2 = c; end
    #1;
    chk({nm, " ack"}, 32'(u == 0 ? ack1 : ack2), 32'(ea));
    chk({nm, " busy"}, 32'(u == 0 ? b1 : b2), 32'(eb));
    if ((ea & r) != 0) begin
      if (u == 0) q1.push_back(f);
      else q2.push_back(f);
    end
  endtask
  task automatic settle();
    @(negedge clk); #1;
    req1 = '0; req2 = '0; cr1 = 1'b0; cr2 = 1'b0;
    #1;
  endtask
  initial begin
    req1 = 5'b11111;
    #12;
    chk("reset ack", 32'(ack1), 0);
    chk("reset valid", 32'(v1), 0);
    chk("reset busy", 32'(b1), 0);
    chk("reset ovf", 32'(ov1), 0);
    chk("reset credits", 32'(u_dut.r_credits), 4);
    chk("reset credits2", 32'(u_dut2.r_credits), 2);
    req1 = '0;
    @(negedge clk); #1 rst_n = 1'b1;
    step(0, 5'b00000, HEAD, 16'h0, 1'b1, 5'b00000, 1'b0, "ovf pulse");
    settle();
    chk("ovf set", 32'(ov1), 1);
    chk("ovf credits", 32'(u_dut.r_credits), 4);
    step(0, 5'b00100, HEAD_TAIL, 16'hA001, 1'b0, 5'b00100, 1'b0, "A ht2");
    settle();
    chk("A valid", 32'(v1), 1);
    chk("A credits", 32'(u_dut.r_credits), 3);
    chk("A rr", 32'(u_dut.r_rr_ptr), 3);
    step(0, 5'b10000, HEAD_TAIL, 16'hA002, 1'b1, 5'b10000, 1'b0, "A ht4");
    for (int i = 0; i < 4; i++) begin
      step(0, 5'b01001, HEAD_TAIL, 16'hB000 + 16'(i), 1'b1,
           (i % 2 == 1) ? 5'b01000 : 5'b00001, 1'b0, "B alt");
      if (i > 0) chk("B valid", 32'(v1), 1);
    end
    settle();
    chk("B credits", 32'(u_dut.r_credits), 3);
    chk("B rr", 32'(u_dut.r_rr_ptr), 4);
    step(0, 5'b00001, HEAD_TAIL, 16'hC001, 1'b0, 5'b00001, 1'b0, "X ht0");
    step(0, 5'b00100, HEAD_TAIL, 16'hC002, 1'b1, 5'b00100, 1'b0, "X ht2 credit");
    settle();
    chk("X xfer+credit", 32'(u_dut.r_credits), 2);
    step(0, 5'b00001, HEAD_TAIL, 16'hC003, 1'b1, 5'b00001, 1'b0, "X ht0b");
    step(0, 5'b10010, HEAD, 16'hD001, 1'b1, 5'b00010, 1'b0, "C head");
    step(0, 5'b10010, BODY, 16'hD002, 1'b1, 5'b00010, 1'b1, "C body");
    step(0, 5'b10010, TAIL, 16'hD003, 1'b1, 5'b00010, 1'b1, "C tail");
    step(0, 5'b10000, HEAD_TAIL, 16'hD004, 1'b1, 5'b10000, 1'b0, "C in4");
    settle();
    chk("C busy", 32'(b1), 0);
    chk("C ovf sticky", 32'(ov1), 1);
    chk("C credits", 32'(u_dut.r_credits), 2);
    chk("C rr", 32'(u_dut.r_rr_ptr), 0);
    step(1, 5'b00010, HEAD, 16'hE001, 1'b0, 5'b00010, 1'b0, "D head");
    step(1, 5'b01010, BODY, 16'hE002, 1'b0, 5'b00010, 1'b1, "D body");
    step(1, 5'b01010, TAIL, 16'hE003, 1'b0, 5'b00000, 1'b1, "D stall");
    chk("D credits0", 32'(u_dut2.r_credits), 0);
    step(1, 5'b01010, TAIL, 16'hE003, 1'b1, 5'b00000, 1'b1, "D credit");
    step(1, 5'b01010, TAIL, 16'hE003, 1'b0, 5'b00010, 1'b1, "D tail");
    step(1, 5'b01010, HEAD_TAIL, 16'hE004, 1'b1, 5'b00000, 1'b0, "D nocred");
    settle();
    chk("D credits1", 32'(u_dut2.r_credits), 1);
    step(1, 5'b01010, HEAD_TAIL, 16'hE005, 1'b0, 5'b01000, 1'b0, "D rr");
    settle();
    step(0, 5'b00100, HEAD, 16'hF001, 1'b0, 5'b00100, 1'b0, "E head");
    @(negedge clk); #1;
    rst_n = 1'b0;
    req1 = 5'b11111;
    #1;
    chk("E rst valid", 32'(v1), 0);
    chk("E rst busy", 32'(b1), 0);
    chk("E rst ack", 32'(ack1), 0);
    chk("E rst credits", 32'(u_dut.r_credits), 4);
    @(negedge clk); #1;
    chk("E rst ack hold", 32'(ack1), 0);
    req1 = '0;
    rst_n = 1'b1;
    step(0, 5'b01000, HEAD, 16'hF002, 1'b0, 5'b01000, 1'b0, "E new head");
    step(0, 5'b01000, TAIL, 16'hF003, 1'b0, 5'b01000, 1'b1, "E new tail");
    settle();
    chk("E busy", 32'(b1), 0);
    chk("E ovf cleared", 32'(ov1), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    chk("q2 drained", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
